// File: rtl/ahb_bridge_pkg.sv
// Shared AHB encodings, responder state enum and the byte-lane mask helper.
package ahb_bridge_pkg;

    typedef enum logic {
        HTRANS_IDLE   = 1'b0,
        HTRANS_NONSEQ = 1'b1
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ERR1  = 3'd2,
        ST_ERR2  = 3'd3,
        ST_SLEEP = 3'd4
    } resp_state_e;

    // Little-endian lane enables for a transfer of 2**size bytes starting at
    // lane 'low'. Sized for buses up to 64 bits; callers truncate to their width.
    function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] low);
        logic [7:0] base;
        case (size)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << low;
    endfunction

endpackage

// File: rtl/ahb_resp_mem.sv
// Word-organised register file: synchronous per-byte write, combinational read.
module ahb_resp_mem
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_DEPTH  = 16,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [BYTES-1:0]      we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [MEM_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

    // Clear everything on reset, otherwise update only the enabled byte lanes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else begin
            for (int b = 0; b < BYTES; b++) begin
                if (we_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb_sink_responder.sv
// AHB-lite memory-backed slave with programmable wait states, two-cycle
// ERROR response for illegal transfers and a sleep handshake.
module ahb_sink_responder
    import ahb_bridge_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 16,
    parameter int                    WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  i_clk_sink,
    input  logic                  i_rst_sink,
    input  logic                  i_hselx,
    input  logic                  i_htrans,
    input  logic [2:0]            i_hsize,
    input  logic                  i_hwrite,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hready,
    input  logic                  i_sleep_req,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_sleep_ack
);

    localparam int                    BYTES     = DATA_WIDTH / 8;
    localparam int                    LANE_W    = $clog2(BYTES);
    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(BYTES * MEM_DEPTH);
    localparam logic [2:0]            WS        = 3'(WAIT_STATES);

    resp_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range, misaligned, legal;
    logic                  done, can_accept, accept;
    logic [BYTES-1:0]      we;
    logic [DATA_WIDTH-1:0] rdata;

    // Address decode on the live address phase; only the word index and the
    // lane offset are kept, since that is all the data phase needs.
    assign offset     = i_haddr - BASE_ADDR;
    assign in_range   = (i_haddr >= BASE_ADDR) && (offset < MEM_BYTES);
    assign misaligned = ((i_hsize == HSIZE_HALF) && i_haddr[0]) ||
                        ((i_hsize == HSIZE_WORD) && (i_haddr[1:0] != 2'b00));
    assign legal      = in_range && (i_hsize <= HSIZE_WORD) && !misaligned &&
                        (state_q != ST_SLEEP);

    // A data phase completes in the last WAIT cycle; a new address phase may
    // overlap it, or follow idle, sleep or the second error cycle.
    assign done       = (state_q == ST_WAIT) && (cnt_q == WS);
    assign can_accept = (state_q inside {ST_IDLE, ST_SLEEP, ST_ERR2}) || done;
    assign accept     = can_accept && i_hselx && (i_htrans == HTRANS_NONSEQ) && i_hready;

    // Next-state, captured address phase and bus response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        size_d      = size_q;
        write_d     = write_q;
        o_hreadyout = 1'b1;
        o_hresp     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_sleep_req) state_d = ST_SLEEP;
            end
            ST_WAIT: begin
                o_hreadyout = done;
                if (done) state_d = ST_IDLE;
                else      cnt_d   = cnt_q + 3'd1;
            end
            ST_ERR1: begin
                o_hreadyout = 1'b0;
                o_hresp     = 1'b1;
                state_d     = ST_ERR2;
            end
            ST_ERR2: begin
                o_hresp = 1'b1;
                state_d = ST_IDLE;
            end
            ST_SLEEP: begin
                if (!i_sleep_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d = legal ? ST_WAIT : ST_ERR1;
            cnt_d   = 3'd0;
            idx_d   = offset[LANE_W +: IDX_W];
            lane_d  = offset[LANE_W-1:0];
            size_d  = i_hsize;
            write_d = i_hwrite;
        end

        // Reset forces the idle response immediately, not just after the edge.
        if (i_rst_sink) begin
            o_hreadyout = 1'b1;
            o_hresp     = 1'b0;
        end
    end

    // State and captured address-phase registers.
    always_ff @(posedge i_clk_sink) begin
        if (i_rst_sink) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Write lanes only in the completing cycle; a concurrent reset aborts it.
    assign we = (done && write_q && !i_rst_sink) ? BYTES'(lane_mask(size_q, 3'(lane_q))) : '0;

    ahb_resp_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk_i   (i_clk_sink),
        .rst_i   (i_rst_sink),
        .we_i    (we),
        .idx_i   (idx_q),
        .wdata_i (i_hwdata),
        .rdata_o (rdata)
    );

    assign o_hrdata    = (done && !write_q && !i_rst_sink) ? rdata : '0;
    assign o_sleep_ack = (state_q == ST_SLEEP) && !i_rst_sink;

endmodule

// File: tb/tb_ahb_sink_responder.sv
// Directed bench: table of single transfers on a WAIT_STATES=1 instance plus
// hand sequences for pipelining, zero-wait, sleep and reset corner cases.
module tb_ahb_sink_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hsel, htrans, hwrite, sleep_req, hready;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hreadyout, hresp, sleep_ack;

    logic        z_hsel, z_htrans, z_hwrite, z_sleep_req, z_hready;
    logic [2:0]  z_hsize;
    logic [31:0] z_haddr, z_hwdata, z_hrdata;
    logic        z_hreadyout, z_hresp, z_sleep_ack;

    // Single-slave bus: HREADY is the slave's own HREADYOUT.
    assign hready   = hreadyout;
    assign z_hready = z_hreadyout;

    ahb_sink_responder #(.WAIT_STATES(1)) u_dut (
        .i_clk_sink (clk),       .i_rst_sink (rst),
        .i_hselx    (hsel),      .i_htrans   (htrans),
        .i_hsize    (hsize),     .i_hwrite   (hwrite),
        .i_haddr    (haddr),     .i_hwdata   (hwdata),
        .i_hready   (hready),    .i_sleep_req(sleep_req),
        .o_hreadyout(hreadyout), .o_hresp    (hresp),
        .o_hrdata   (hrdata),    .o_sleep_ack(sleep_ack)
    );

    ahb_sink_responder #(.WAIT_STATES(0)) u_dut0 (
        .i_clk_sink (clk),         .i_rst_sink (rst),
        .i_hselx    (z_hsel),      .i_htrans   (z_htrans),
        .i_hsize    (z_hsize),     .i_hwrite   (z_hwrite),
        .i_haddr    (z_haddr),     .i_hwdata   (z_hwdata),
        .i_hready   (z_hready),    .i_sleep_req(z_sleep_req),
        .o_hreadyout(z_hreadyout), .o_hresp    (z_hresp),
        .o_hrdata   (z_hrdata),    .o_sleep_ack(z_sleep_ack)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt[16];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        hsel = 1'b0; htrans = 1'b0; hwrite = 1'b0; hsize = 3'd0; haddr = '0; hwdata = '0;
    endtask

    // One non-pipelined transfer on the WAIT_STATES=1 instance.
    task automatic xfer(input int id, input vec_t v);
        int waits;
        hsel = 1'b1; htrans = 1'b1; hwrite = v.wr; hsize = v.size; haddr = v.addr;
        cyc();
        hsel = 1'b0; htrans = 1'b0; hwdata = v.wdata;
        if (v.err) begin
            chk($sformatf("v%0d err1 ready", id), 32'(hreadyout), 32'd0);
            chk($sformatf("v%0d err1 resp", id), 32'(hresp), 32'd1);
            cyc();
            chk($sformatf("v%0d err2 ready", id), 32'(hreadyout), 32'd1);
            chk($sformatf("v%0d err2 resp", id), 32'(hresp), 32'd1);
            cyc();
        end else begin
            waits = 0;
            while (hreadyout !== 1'b1 && waits < 20) begin
                chk($sformatf("v%0d rdata in wait", id), hrdata, 32'd0);
                waits++;
                cyc();
            end
            chk($sformatf("v%0d wait cycles", id), 32'(waits), 32'd1);
            chk($sformatf("v%0d resp", id), 32'(hresp), 32'd0);
            chk($sformatf("v%0d rdata", id), hrdata, v.wr ? 32'd0 : v.rdata);
            cyc();
        end
        hwdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tmp;
        //          wr    size  addr    wdata         err   rdata
        vt[0]  = '{1'b1, 3'd2, 32'h04, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 3'd2, 32'h04, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 3'd0, 32'h09, 32'h5555AA55, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 3'd2, 32'h08, 32'h0,        1'b0, 32'h0000AA00};
        vt[4]  = '{1'b0, 3'd2, 32'h40, 32'h0,        1'b1, 32'h0};
        vt[5]  = '{1'b1, 3'd2, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h0};
        vt[6]  = '{1'b0, 3'd2, 32'h00, 32'h0,        1'b0, 32'h0};
        vt[7]  = '{1'b0, 3'd1, 32'h03, 32'h0,        1'b1, 32'h0};
        vt[8]  = '{1'b0, 3'd2, 32'h00, 32'h0,        1'b0, 32'h0};
        vt[9]  = '{1'b1, 3'd1, 32'h06, 32'hCAFE5678, 1'b0, 32'h0};
        vt[10] = '{1'b0, 3'd2, 32'h04, 32'h0,        1'b0, 32'hCAFEBEEF};
        vt[11] = '{1'b1, 3'd3, 32'h00, 32'hFFFFFFFF, 1'b1, 32'h0};
        vt[12] = '{1'b1, 3'd2, 32'h02, 32'hFFFFFFFF, 1'b1, 32'h0};
        vt[13] = '{1'b0, 3'd2, 32'h00, 32'h0,        1'b0, 32'h0};
        vt[14] = '{1'b1, 3'd0, 32'h3F, 32'h77000000, 1'b0, 32'h0};
        vt[15] = '{1'b0, 3'd2, 32'h3C, 32'h0,        1'b0, 32'h77000000};

        idle_bus();
        sleep_req = 1'b0;
        z_hsel = 1'b0; z_htrans = 1'b0; z_hwrite = 1'b0; z_hsize = 3'd0;
        z_haddr = '0; z_hwdata = '0; z_sleep_req = 1'b0;
        rst = 1'b1;
        repeat (3) cyc();

        // Values while reset is held.
        chk("reset ready", 32'(hreadyout), 32'd1);
        chk("reset resp", 32'(hresp), 32'd0);
        chk("reset rdata", hrdata, 32'd0);
        chk("reset ack", 32'(sleep_ack), 32'd0);
        chk("reset ready ws0", 32'(z_hreadyout), 32'd0 + 32'd1);
        rst = 1'b0;
        cyc();

        // Selected but IDLE, then NONSEQ but not selected: no transfer starts.
        hsel = 1'b1; htrans = 1'b0; haddr = 32'h4;
        cyc();
        chk("idle htrans ready", 32'(hreadyout), 32'd1);
        chk("idle htrans resp", 32'(hresp), 32'd0);
        hsel = 1'b0; htrans = 1'b1;
        cyc();
        chk("unselected ready", 32'(hreadyout), 32'd1);
        idle_bus();
        cyc();

        for (int i = 0; i < 16; i++) xfer(i, vt[i]);

        // Pipelined write then read of the same word, read address held
        // through the write's wait cycle.
        hsel = 1'b1; htrans = 1'b1; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
        cyc();
        chk("pipe w wait ready", 32'(hreadyout), 32'd0);
        hwdata = 32'h0BADF00D; hwrite = 1'b0;
        cyc();
        chk("pipe w done ready", 32'(hreadyout), 32'd1);
        chk("pipe w done resp", 32'(hresp), 32'd0);
        chk("pipe w done rdata", hrdata, 32'd0);
        cyc();
        chk("pipe r no idle", 32'(hreadyout), 32'd0);
        hsel = 1'b0; htrans = 1'b0; hwdata = '0;
        cyc();
        chk("pipe r ready", 32'(hreadyout), 32'd1);
        chk("pipe r rdata", hrdata, 32'h0BADF00D);
        cyc();
        chk("pipe after rdata", hrdata, 32'd0);

        // Zero-wait instance: back-to-back write then read of word 0.
        z_hsel = 1'b1; z_htrans = 1'b1; z_hwrite = 1'b1; z_hsize = 3'd2; z_haddr = 32'h0;
        cyc();
        chk("ws0 write ready", 32'(z_hreadyout), 32'd1);
        chk("ws0 write rdata", z_hrdata, 32'd0);
        z_hwdata = 32'h11223344; z_hwrite = 1'b0;
        cyc();
        chk("ws0 read ready", 32'(z_hreadyout), 32'd1);
        chk("ws0 read resp", 32'(z_hresp), 32'd0);
        chk("ws0 read rdata", z_hrdata, 32'h11223344);
        z_hsel = 1'b0; z_htrans = 1'b0; z_hwdata = '0;
        cyc();
        chk("ws0 idle rdata", z_hrdata, 32'd0);

        // Sleep requested mid data phase: ack waits for completion and idle.
        hsel = 1'b1; htrans = 1'b1; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h4;
        cyc();
        hsel = 1'b0; htrans = 1'b0; sleep_req = 1'b1;
        chk("sleep wait ack", 32'(sleep_ack), 32'd0);
        cyc();
        chk("sleep done ack", 32'(sleep_ack), 32'd0);
        chk("sleep done rdata", hrdata, 32'hCAFEBEEF);
        cyc();
        chk("sleep idle ack", 32'(sleep_ack), 32'd0);
        cyc();
        chk("sleep ack rise", 32'(sleep_ack), 32'd1);
        hsel = 1'b1; htrans = 1'b1; haddr = 32'h0;
        cyc();
        hsel = 1'b0; htrans = 1'b0;
        chk("asleep err1 ready", 32'(hreadyout), 32'd0);
        chk("asleep err1 resp", 32'(hresp), 32'd1);
        cyc();
        chk("asleep err2 ready", 32'(hreadyout), 32'd1);
        chk("asleep err2 resp", 32'(hresp), 32'd1);
        cyc();
        cyc();
        chk("resleep ack", 32'(sleep_ack), 32'd1);
        sleep_req = 1'b0;
        cyc();
        chk("wake ack", 32'(sleep_ack), 32'd0);
        tmp = '{1'b0, 3'd2, 32'h04, 32'h0, 1'b0, 32'hCAFEBEEF};
        xfer(20, tmp);

        // Reset in the middle of a write's wait cycle.
        tmp = '{1'b1, 3'd2, 32'h14, 32'hA5A5A5A5, 1'b0, 32'h0};
        xfer(21, tmp);
        hsel = 1'b1; htrans = 1'b1; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h14;
        cyc();
        hsel = 1'b0; htrans = 1'b0; hwdata = 32'hFFFFFFFF; rst = 1'b1;
        #1;
        chk("rst mid ready", 32'(hreadyout), 32'd1);
        chk("rst mid resp", 32'(hresp), 32'd0);
        cyc();
        rst = 1'b0; hwdata = '0;
        chk("rst after ready", 32'(hreadyout), 32'd1);
        chk("rst after resp", 32'(hresp), 32'd0);
        cyc();
        tmp = '{1'b0, 3'd2, 32'h14, 32'h0, 1'b0, 32'h0};
        xfer(22, tmp);
        tmp = '{1'b0, 3'd2, 32'h04, 32'h0, 1'b0, 32'h0};
        xfer(23, tmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
